// File: rtl/packer_pkg.sv
// Shared types and helpers for the AXI-Stream byte packer.
package packer_pkg;

    typedef enum logic [0:0] {ACCUM, DRAIN_LAST} state_e;

    // Widest byte-enable vector the helper functions accept.
    localparam int unsigned MAX_BYTES = 64;

    function automatic logic [7:0] keep_popcount(input logic [MAX_BYTES-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt = cnt + 8'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [MAX_BYTES-1:0] count_to_keep(input logic [7:0] count);
        logic [MAX_BYTES-1:0] mask;
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[i] = (i < int'(count));
        end
        return mask;
    endfunction

endpackage

// File: rtl/packer_byte_merge.sv
// Inserts the valid bytes of an input beat into the accumulator at byte offset fill, and
// provides the accumulator shifted down by one output word for the post-emit remainder.
module packer_byte_merge #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 8,
    parameter int CW        = $clog2(OUT_BYTES + IN_BYTES) + 1,
    parameter int ACC_BYTES = OUT_BYTES + IN_BYTES - 1
) (
    input  logic [ACC_BYTES*8-1:0] acc,
    input  logic [CW-1:0]          fill,
    input  logic [CW-1:0]          n,
    input  logic [IN_BYTES*8-1:0]  data,
    output logic [ACC_BYTES*8-1:0] merged,
    output logic [ACC_BYTES*8-1:0] shifted
);

    always_comb begin
        merged = acc;
        for (int i = 0; i < ACC_BYTES; i++) begin
            for (int j = 0; j < IN_BYTES; j++) begin
                if ((j < int'(n)) && (i == int'(fill) + j)) begin
                    merged[i*8 +: 8] = data[j*8 +: 8];
                end
            end
        end
        shifted = merged >> (OUT_BYTES * 8);
    end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs narrow LSB-aligned AXI-Stream beats densely into wide words; partial words flush on tlast.
// Optional word/packet counters are built when PACKER_STATS_EN is defined.
module axis_byte_packer #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 8,
    parameter int CW        = $clog2(OUT_BYTES + IN_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_BYTES*8-1:0]  s_axis_tdata,
    input  logic [IN_BYTES-1:0]    s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [OUT_BYTES*8-1:0] m_axis_tdata,
    output logic [OUT_BYTES-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   pause
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]            word_cnt,
    output logic [31:0]            pkt_cnt
`endif
);
    import packer_pkg::*;

    localparam int ACC_BYTES = OUT_BYTES + IN_BYTES - 1;
    localparam int ACC_W     = ACC_BYTES * 8;
    localparam int OUT_W     = OUT_BYTES * 8;
    localparam logic [CW-1:0] OUT_CNT = CW'(OUT_BYTES);

    state_e                 state_q, state_d;
    logic [CW-1:0]          fill_q, fill_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       merged, shifted;
    logic [CW-1:0]          n, total, rem;
    logic                   out_free, accept;
    logic                   load, load_last;
    logic [OUT_BYTES-1:0]   load_keep;
    logic [OUT_W-1:0]       load_raw, load_data;

    assign out_free      = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = rst_n & (state_q == ACCUM) & ~pause & out_free;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign n             = CW'(keep_popcount(MAX_BYTES'(s_axis_tkeep)));
    assign total         = fill_q + n;
    assign rem           = total - OUT_CNT;

    packer_byte_merge #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .CW        (CW),
        .ACC_BYTES (ACC_BYTES)
    ) u_merge (
        .acc     (acc_q),
        .fill    (fill_q),
        .n       (n),
        .data    (s_axis_tdata),
        .merged  (merged),
        .shifted (shifted)
    );

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        acc_d     = acc_q;
        load      = 1'b0;
        load_last = 1'b0;
        load_keep = '0;
        load_raw  = '0;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = merged;
                    if (total >= OUT_CNT) begin
                        load      = 1'b1;
                        load_raw  = merged[OUT_W-1:0];
                        load_keep = '1;
                        acc_d     = shifted;
                        fill_d    = rem;
                        if (s_axis_tlast) begin
                            if (rem != '0) state_d = DRAIN_LAST;
                            else           load_last = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        // total==0 with tlast is consumed silently.
                        load      = (total != '0);
                        load_raw  = merged[OUT_W-1:0];
                        load_keep = OUT_BYTES'(count_to_keep(8'(total)));
                        load_last = 1'b1;
                        fill_d    = '0;
                    end else begin
                        fill_d = total;
                    end
                end
            end
            DRAIN_LAST: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_raw  = acc_q[OUT_W-1:0];
                    load_keep = OUT_BYTES'(count_to_keep(8'(fill_q)));
                    load_last = 1'b1;
                    fill_d    = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Bytes outside tkeep are zeroed so stale accumulator contents never leak out.
        load_data = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (load_keep[i]) load_data[i*8 +: 8] = load_raw[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            fill_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= load_last;
            m_axis_tkeep  <= load_keep;
            m_axis_tdata  <= load_data;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef PACKER_STATS_EN
    logic out_hs;
    assign out_hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (out_hs) begin
            word_cnt <= word_cnt + 32'd1;
            if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif

endmodule
